fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001 Parameter: PC_RESET, default 64'h8000_0000, PC loaded on reset.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 ireq_valid  output  1  instruction-bus request valid.
- REQ-005 ireq_addr  output  64  instruction-bus request address (u64).
- REQ-006 iresp_data_ok  input  1  instruction-bus response valid this cycle.
- REQ-007 iresp_data  input  32  instruction word returned with iresp_data_ok.
- REQ-008 stall  input  1  decode cannot accept the held instruction this cycle.
- REQ-009 redirect_valid  input  1  branch/jump resolution: change fetch PC.
- REQ-010 redirect_pc  input  64  new fetch PC when redirect_valid=1.
- REQ-011 dataF  output  fetch_data_t  {pc (u64), raw_instr (u32), valid}; consumed by the decode stage.

Function
- REQ-012 State machine SHALL have two states: REQ (instruction request outstanding) and HOLD (instruction buffered for decode).
- REQ-013 In REQ: ireq_valid=1, ireq_addr=pc, dataF.valid=0.
- REQ-014 In HOLD: ireq_valid=0, dataF.valid=1, dataF.pc=pc, dataF.raw_instr=buffered word.
- REQ-015 ireq_addr SHALL stay stable from first assertion of ireq_valid until the cycle iresp_data_ok=1; a redirect never changes ireq_addr mid-request.
- REQ-016 REQ, iresp_data_ok=1, no drop pending, no redirect: capture iresp_data into buffer; next state HOLD.
- REQ-017 HOLD, stall=0, no redirect: instruction consumed at this edge; pc <= pc+4 (modulo 2^64, wrap from all-ones region to 0 permitted); next state REQ.
- REQ-018 HOLD, stall=1, no redirect: pc, buffer, state unchanged; dataF stable.
- REQ-019 HOLD, redirect_valid=1 (regardless of stall): pc <= redirect_pc; buffered instruction discarded; next state REQ.
- REQ-020 REQ, redirect_valid=1, iresp_data_ok=0: set drop flag, save redirect_pc in pending register; stay REQ with old ireq_addr.
- REQ-021 REQ, redirect_valid=1 while drop flag already set: pending register overwritten; last redirect wins.
- REQ-022 REQ, iresp_data_ok=1 with drop flag set and no new redirect: response discarded; pc <= pending; drop flag cleared; stay REQ; new request issued next cycle.
- REQ-023 REQ, iresp_data_ok=1 and redirect_valid=1 same cycle: response discarded; pc <= redirect_pc; drop flag cleared; stay REQ.
- REQ-024 redirect_pc[1:0] SHALL be forced to 0 when loaded.
- REQ-025 stall SHALL have no effect in REQ.
- REQ-026 Peak throughput: one instruction per 2 cycles with zero-wait memory; no instruction SHALL be delivered twice or skipped except by redirect.
- REQ-027 All outputs derived from registered state only (no combinational path from iresp_* or redirect_* to dataF).

Reset
- REQ-028 While reset=1 at an edge: pc <= PC_RESET, state <= REQ, drop flag <= 0, pending <= 0, buffer <= 0.
- REQ-029 During the reset cycle and the first cycle after: dataF.valid=0; ireq_valid=0 while reset=1, 1 from first cycle with reset=0.
- REQ-030 Reset mid-request: outstanding response arriving after reset is treated as the response to the new request at PC_RESET; bus SHALL guarantee no in-flight response across reset.

Verification
- REQ-031 Reset, zero-wait memory returning 32'h0000_0013 -> dataF.valid pulses every 2nd cycle, dataF.pc 0x8000_0000, 0x8000_0004, 0x8000_0008.
- REQ-032 HOLD with stall=1 for 3 cycles -> dataF constant, ireq_valid=0 for 3 cycles, then pc advances by 4 once stall=0.
- REQ-033 Request to 0x8000_0010 with 3-cycle latency, redirect to 0x8000_0100 on cycle 1 -> ireq_addr held at 0x8000_0010, response dropped, next ireq_addr 0x8000_0100, no dataF.valid for 0x8000_0010.
- REQ-034 redirect_valid and iresp_data_ok same cycle, redirect_pc 0x8000_0203 -> response dropped, next ireq_addr 0x8000_0200.
- REQ-035 HOLD with stall=1 and redirect to 0x8000_0040 -> dataF.valid=0 next cycle, next ireq_addr 0x8000_0040.
- REQ-036 Two redirects (0x8000_0A00 then 0x8000_0B00) during one outstanding request -> single refetch at 0x8000_0B00.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one request in flight, one instruction buffered for decode.
// Redirects arriving mid-request are parked until the outstanding response drains.
package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        drop_q, drop_d;
  logic [63:0] pend_q, pend_d;
  logic [63:0] rpc_al;

  assign rpc_al = redirect_pc & ~64'h3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    case (state_q)
      S_REQ: begin
        // pc only moves when the response lands, keeping ireq_addr stable
        if (iresp_data_ok) begin
          drop_d = 1'b0;
          if (redirect_valid) begin
            pc_d = rpc_al;
          end else if (drop_q) begin
            pc_d = pend_q;
          end else begin
            buf_d   = iresp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
          pend_d = rpc_al;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_d    = rpc_al;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= PC_RESET;
      buf_q   <= '0;
      drop_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
    end
  end

  assign ireq_valid      = (state_q == S_REQ) && !reset;
  assign ireq_addr       = pc_q;
  assign dataF.pc        = pc_q;
  assign dataF.raw_instr = buf_q;
  assign dataF.valid     = (state_q == S_HOLD) && !reset;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact directed vector table, then a randomized
// memory/stall/redirect run checked through a delivery scoreboard.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;

  fetch_stage #(.PC_RESET(A)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dataF(dataF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ok;
    logic [31:0] d;
    logic        stl, rv;
    logic [63:0] rpc;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_dv;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t v(input logic rst, input logic ok, input logic [31:0] d,
                             input logic stl, input logic rv, input logic [63:0] rpc,
                             input logic e_iv, input logic [63:0] e_addr,
                             input logic e_dv, input logic [63:0] e_pc, input logic [31:0] e_ins);
    vec_t r;
    r.rst = rst; r.ok = ok; r.d = d; r.stl = stl; r.rv = rv; r.rpc = rpc;
    r.e_iv = e_iv; r.e_addr = e_addr; r.e_dv = e_dv; r.e_pc = e_pc; r.e_ins = e_ins;
    return r;
  endfunction

  function automatic logic [31:0] h(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ok, input logic [31:0] d,
                       input logic stl, input logic rv, input logic [63:0] rpc);
    reset = rst; iresp_data_ok = ok; iresp_data = d;
    stall = stl; redirect_valid = rv; redirect_pc = rpc;
  endtask

  initial begin
    logic        drop, outst, prev_dv, rv_n, stl_n;
    logic [63:0] pend, req_addr, exp_next, rpc_n;
    int          lat;
    exp_t        e;

    // rst ok data stall rv rpc | iv addr | dv pc instr
    tbl.push_back(v(1,0,0,0,0,0,                 0,0,       0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,                 0,0,       0,0,0));
    tbl.push_back(v(0,1,32'h13,0,0,0,            0,0,       1,A,32'h13));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+4,     0,0,0));
    tbl.push_back(v(0,1,32'h13,0,0,0,            0,0,       1,A+4,32'h13));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+8,     0,0,0));
    tbl.push_back(v(0,1,32'h13,0,0,0,            0,0,       1,A+8,32'h13));
    tbl.push_back(v(0,0,0,1,0,0,                 0,0,       1,A+8,32'h13));
    tbl.push_back(v(0,0,0,1,0,0,                 0,0,       1,A+8,32'h13));
    tbl.push_back(v(0,0,0,1,0,0,                 0,0,       1,A+8,32'h13));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'hC,   0,0,0));
    tbl.push_back(v(0,1,32'h1111,0,0,0,          0,0,       1,A+'hC,32'h1111));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'h10,  0,0,0));
    // 3-cycle latency request, redirect in its first cycle
    tbl.push_back(v(0,0,0,0,1,A+'h100,           1,A+'h10,  0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'h10,  0,0,0));
    tbl.push_back(v(0,1,32'hDEAD,0,0,0,          1,A+'h100, 0,0,0));
    tbl.push_back(v(0,1,32'h2222,0,0,0,          0,0,       1,A+'h100,32'h2222));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'h104, 0,0,0));
    // response and unaligned redirect together
    tbl.push_back(v(0,1,32'hBAD,0,1,A+'h203,     1,A+'h200, 0,0,0));
    tbl.push_back(v(0,1,32'h3333,0,0,0,          0,0,       1,A+'h200,32'h3333));
    // redirect during stalled HOLD; stall ignored in REQ
    tbl.push_back(v(0,0,0,1,1,A+'h40,            1,A+'h40,  0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,                 1,A+'h40,  0,0,0));
    tbl.push_back(v(0,1,32'h4444,1,0,0,          0,0,       1,A+'h40,32'h4444));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'h44,  0,0,0));
    // two redirects during one request: last wins
    tbl.push_back(v(0,0,0,0,1,A+'hA00,           1,A+'h44,  0,0,0));
    tbl.push_back(v(0,0,0,0,1,A+'hB00,           1,A+'h44,  0,0,0));
    tbl.push_back(v(0,1,32'h5555,0,0,0,          1,A+'hB00, 0,0,0));
    tbl.push_back(v(0,1,32'h6666,0,0,0,          0,0,       1,A+'hB00,32'h6666));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A+'hB04, 0,0,0));
    // pending redirect near the top of the address space, then wrap to 0
    tbl.push_back(v(0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFF, 1,A+'hB04, 0,0,0));
    tbl.push_back(v(0,1,32'h7777,0,0,0,          1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0));
    tbl.push_back(v(0,1,32'h8888,0,0,0,          0,0,       1,64'hFFFF_FFFF_FFFF_FFFC,32'h8888));
    tbl.push_back(v(0,0,0,0,0,0,                 1,64'h0,   0,0,0));
    // reset mid-request and during HOLD
    tbl.push_back(v(1,0,0,0,0,0,                 0,0,       0,0,0));
    tbl.push_back(v(0,1,32'h9999,0,0,0,          0,0,       1,A,32'h9999));
    tbl.push_back(v(1,0,0,0,0,0,                 0,0,       0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,                 1,A,       0,0,0));

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ok, tbl[i].d, tbl[i].stl, tbl[i].rv, tbl[i].rpc);
      @(posedge clk); #1;
      chk($sformatf("row%0d ireq_valid", i), 64'(ireq_valid), 64'(tbl[i].e_iv));
      chk($sformatf("row%0d dataF.valid", i), 64'(dataF.valid), 64'(tbl[i].e_dv));
      if (tbl[i].e_iv) chk($sformatf("row%0d ireq_addr", i), ireq_addr, tbl[i].e_addr);
      if (tbl[i].e_dv) begin
        chk($sformatf("row%0d dataF.pc", i), dataF.pc, tbl[i].e_pc);
        chk($sformatf("row%0d dataF.instr", i), 64'(dataF.raw_instr), 64'(tbl[i].e_ins));
      end
      @(negedge clk);
    end

    // randomized phase: variable-latency memory, random stalls and redirects
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drop = 0; outst = 0; prev_dv = 0; pend = '0; req_addr = '0; exp_next = A; lat = 0;
    for (int c = 0; c < 600; c++) begin
      if (dataF.valid && !prev_dv) begin
        if (sb.size() == 0) begin
          chk("rand unexpected delivery pc", dataF.pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rand delivery pc", dataF.pc, e.pc);
          chk("rand delivery instr", 64'(dataF.raw_instr), 64'(e.ins));
        end
      end
      prev_dv = dataF.valid;
      stl_n = ($urandom_range(0, 2) == 0);
      rv_n  = ($urandom_range(0, 9) == 0);
      rpc_n = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      iresp_data_ok = 1'b0;
      iresp_data = $urandom;
      if (ireq_valid) begin
        if (!outst) begin
          outst = 1; req_addr = ireq_addr; lat = $urandom_range(0, 3);
          chk("rand request addr", ireq_addr, exp_next);
        end else begin
          chk("rand addr stable", ireq_addr, req_addr);
        end
        if (lat == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data = h(req_addr);
          outst = 0;
          if (rv_n) exp_next = rpc_n & ~64'h3;
          else if (drop) exp_next = pend;
          else sb.push_back('{pc: req_addr, ins: h(req_addr)});
          drop = 0;
        end else begin
          lat--;
          if (rv_n) begin drop = 1; pend = rpc_n & ~64'h3; end
        end
      end else if (dataF.valid) begin
        if (rv_n) exp_next = rpc_n & ~64'h3;
        else if (!stl_n) exp_next = dataF.pc + 64'd4;
      end
      stall = stl_n; redirect_valid = rv_n; redirect_pc = rpc_n;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rand scoreboard drained", 64'(sb.size() <= 1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
